pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and next-address stage of the single-cycle MIPS core, sitting directly upstream of `instr_mem`. It holds the 32-bit `PC` that addresses instruction memory and computes the next fetch address each cycle from sequential, branch, jump and jump-register inputs. A small run-control FSM handles boot, stall and halt. A retired-instruction counter supports debug and testbenches.

## Interface
- `RESET_ADDR`, default 32'h00000000: first fetch address after reset; must be word-aligned.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; 0 = stall (PC and counter hold).
- `halt`  in  1  stop fetching; sampled only in RUN.
- `branch`  in  1  current instruction is a conditional branch.
- `zero`  in  1  ALU zero flag; a branch is taken when `branch & zero`.
- `branch_imm`  in  16  branch offset, in words, signed.
- `jump`  in  1  J/JAL.
- `jump_target`  in  26  instr[25:0].
- `jr`  in  1  JR.
- `jr_addr`  in  32  register value for JR.
- `PC`  out  32  current fetch address, feeds `instr_mem.PC`.
- `PC_plus4`  out  32  `PC + 4`, combinational, for JAL link.
- `valid`  out  1  PC holds a fetchable instruction (state RUN).
- `instr_count`  out  32  retired-instruction count.
- `misalign`  out  1  sticky misaligned-JR flag (see Configuration).

## Operation
- FSM states: BOOT, RUN, HALTED.
  - `reset` forces BOOT.
  - BOOT goes to RUN after one clock, unconditionally.
  - RUN goes to HALTED on a clock edge with `halt=1`.
  - HALTED is left only by `reset`.
- Reset values: `PC=RESET_ADDR`, `instr_count=0`, `misalign=0`, `valid=0`, state BOOT.
- BOOT: PC stays at `RESET_ADDR`, so the first instruction fetched is at `RESET_ADDR`.
- RUN, edge with `en=1` and `halt=0`:
  - PC loads `next_pc`.
  - `instr_count` increments, saturating at 32'hFFFFFFFF.
- RUN with `en=0`: PC and count hold. `halt` still takes effect.
- RUN with `halt=1`: PC and count hold, regardless of `en`, and the FSM enters HALTED.
- HALTED: PC, count and `misalign` are frozen; `valid=0`.
- `next_pc` priority: `jr` > `jump` > (`branch & zero`) > `PC+4`.
  - Branch: `PC+4 + (sext(branch_imm) << 2)`, modulo 2^32.
  - Jump: `{PC_plus4[31:28], jump_target, 2'b00}`.
  - JR: see Configuration.
- Wrap-around: `PC=32'hFFFFFFFC` sequential gives 0. A branch target past 2^32 wraps silently.
- Simultaneous `jr`, `jump` and `branch`: resolved by priority, no error indication.
- Asserting `reset` mid-RUN or in HALTED: outputs take reset values immediately, without waiting for a clock.

## Timing
- `PC`, `valid`, `instr_count` and `misalign` are registered. `PC_plus4` and `next_pc` are combinational from PC and inputs.
- Control inputs are sampled on the same edge that consumes them. The next PC is visible one cycle after the instruction at the current PC.
- After reset release: BOOT for 1 cycle, then `valid=1` with `PC=RESET_ADDR` for the first RUN cycle.
- Halt latency: `valid` drops the cycle after `halt` is sampled.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A JR with `jr_addr[1:0]!=0` loads `{jr_addr[31:2],2'b00}`.
  - It sets `misalign=1`, which stays set until reset.
- `PC_ALIGN_CHECK_EN` undefined:
  - JR loads `jr_addr` unmodified.
  - `misalign` is tied to 0.

## Structure
- Shared package `pc_pkg`:
  - state encoding `pc_state_t` (BOOT=0, RUN=1, HALTED=2);
  - constant `PC_STEP=4`;
  - the default `RESET_ADDR` value.
- One sub-module, `pc_next`: purely combinational next-address mux and adders (inputs PC, controls; output `next_pc`). The FSM, PC register and counter stay in `pc_unit`.

## Test plan
- Reset with `RESET_ADDR=0`, release, `en=1`, no control: `valid` rises after 1 cycle; PC steps 0, 4, 8, C; `instr_count` reaches 3 after three RUN edges.
- Branch: `PC=8`, `branch=1`, `zero=1`, `branch_imm=16'hFFFE` gives next PC 4. The same with `zero=0` gives C.
- Priority and jump: `PC=32'h10000000`, `jump=1`, `jump_target=26'h0000010` gives 32'h10000040. With `jr=1` and `jr_addr=32'h20` also asserted, the result is 32'h20.
- Stall and halt: `en=0` for 3 cycles holds PC and count. `halt=1` drops `valid` next cycle, after which PC stays frozen despite further controls.
- Wrap and reset: `PC=32'hFFFFFFFC` sequential gives 0. Asserting `reset` asynchronously mid-RUN returns PC to `RESET_ADDR` and count to 0 before the next edge.
- With `PC_ALIGN_CHECK_EN`: `jr_addr=32'h22` gives PC 32'h20 and `misalign=1`, which stays set. Without the macro: PC 32'h22 and `misalign=0`.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / next-address stage.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_STEP            = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

    // Word offset of a branch immediate, sign-extended and scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-fetch-address selection: jr > jump > taken branch > PC+4.
// PC_ALIGN_CHECK_EN forces JR targets to word alignment and reports misalignment.
module pc_next
    import pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        zero,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        jr_misaligned
);

    logic [31:0] jr_target_s;

    // JR target formation and misalignment detection
    always_comb begin
`ifdef PC_ALIGN_CHECK_EN
        jr_target_s   = {jr_addr[31:2], 2'b00};
        jr_misaligned = jr & (jr_addr[1:0] != 2'b00);
`else
        jr_target_s   = jr_addr;
        jr_misaligned = 1'b0;
`endif
    end

    // Priority mux; all adders wrap modulo 2^32
    always_comb begin
        pc_plus4 = pc + PC_STEP;
        if (jr) begin
            next_pc = jr_target_s;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset(branch_imm);
        end else begin
            next_pc = pc_plus4;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter, run-control FSM (BOOT/RUN/HALTED) and retired-instruction counter.
// Optional macro PC_ALIGN_CHECK_EN enables JR alignment and the sticky misalign flag.
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        halt,
    input  logic        branch,
    input  logic        zero,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        valid,
    output logic [31:0] instr_count,
    output logic        misalign
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic        misalign_q, misalign_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc_s;
    logic        jr_misaligned_s;

    pc_next u_pc_next (
        .pc            (pc_q),
        .branch        (branch),
        .zero          (zero),
        .branch_imm    (branch_imm),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .next_pc       (next_pc_s),
        .pc_plus4      (PC_plus4),
        .jr_misaligned (jr_misaligned_s)
    );

    // Next-state, PC advance and counter update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // halt wins over en: nothing retires on the halting edge
                if (halt) begin
                    state_d = HALTED;
                end else if (en) begin
                    pc_d = next_pc_s;
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_d = count_q + 32'd1;
                    end else begin
                        count_d = count_q;
                    end
                    if (jr_misaligned_s) begin
                        misalign_d = 1'b1;
                    end else begin
                        misalign_d = misalign_q;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        valid_d = (state_d == RUN);
    end

    // State, PC, counter and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_ADDR;
            count_q    <= 32'd0;
            misalign_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            valid_q    <= valid_d;
        end
    end

    assign PC          = pc_q;
    assign valid       = valid_q;
    assign instr_count = count_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized control traffic
// checked against an arithmetic reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0, halt = 1'b0, branch = 1'b0, zero = 1'b0;
    logic [15:0] branch_imm = 16'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = 32'd0;
    logic [31:0] PC, PC_plus4, instr_count;
    logic        valid, misalign;

    int checks = 0;
    int errors = 0;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    // Reference model state
    logic [31:0] m_pc;
    longint      m_count;
    bit          m_booting, m_halted, m_mis;

    pc_unit #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .en(en), .halt(halt),
        .branch(branch), .zero(zero), .branch_imm(branch_imm),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
        .PC(PC), .PC_plus4(PC_plus4), .valid(valid),
        .instr_count(instr_count), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_next(input logic [31:0] pc);
        longint t;
        if (jr) begin
            if (ALIGN_CHK) return jr_addr - (jr_addr % 32'd4);
            return jr_addr;
        end
        if (jump) begin
            t = (longint'(pc) + 64'sd4) % 64'sh1_0000_0000;
            t = (t / 64'sh1000_0000) * 64'sh1000_0000 + longint'(jump_target) * 64'sd4;
            return t[31:0];
        end
        if (branch && zero) begin
            t = longint'(pc) + 64'sd4 + longint'($signed(branch_imm)) * 64'sd4;
            return t[31:0];
        end
        t = longint'(pc) + 64'sd4;
        return t[31:0];
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_count = 0; m_booting = 1'b1; m_halted = 1'b0; m_mis = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic cycle(input logic i_en, input logic i_halt, input logic i_br, input logic i_z,
                         input logic [15:0] i_imm, input logic i_j, input logic [25:0] i_jt,
                         input logic i_jr, input logic [31:0] i_ja);
        logic [31:0] nxt;
        en = i_en; halt = i_halt; branch = i_br; zero = i_z; branch_imm = i_imm;
        jump = i_j; jump_target = i_jt; jr = i_jr; jr_addr = i_ja;
        nxt = ref_next(m_pc);
        @(posedge clk);
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (!m_halted) begin
            if (i_halt) begin
                m_halted = 1'b1;
            end else if (i_en) begin
                if (ALIGN_CHK && i_jr && (i_ja % 32'd4) != 0) m_mis = 1'b1;
                m_pc = nxt;
                if (m_count < 64'hFFFF_FFFF) m_count++;
            end
        end
        #1;
    endtask

    task automatic seq(input logic i_en);
        cycle(i_en, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    endtask

    task automatic set_pc(input logic [31:0] a);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, a);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        model_reset();
        checks++;
        if (PC !== 32'h0 || valid !== 1'b0 || instr_count !== 32'd0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: PC=%h valid=%b cnt=%0d mis=%b, want 0/0/0/0", PC, valid, instr_count, misalign);
        end
        reset = 1'b0;
        seq(1'b1);
        checks++;
        if (valid !== 1'b1 || PC !== 32'h0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL boot_exit: valid=%b PC=%h cnt=%0d, want 1/0/0", valid, PC, instr_count);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            seq(1'b1);
            checks++;
            if (PC !== 32'(4 * i) || PC_plus4 !== 32'(4 * i + 4)) begin
                errors++;
                $display("FAIL seq_step%0d: PC=%h PC_plus4=%h, want %h", i, PC, PC_plus4, 32'(4 * i));
            end
        end
        checks++;
        if (instr_count !== 32'd3) begin
            errors++;
            $display("FAIL seq_count: got %0d want 3", instr_count);
        end
    endtask

    task automatic test_branch();
        set_pc(32'h8);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
        checks++;
        if (PC !== 32'h4) begin
            errors++; $display("FAIL branch_taken: got %h want 00000004", PC);
        end
        set_pc(32'h8);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
        checks++;
        if (PC !== 32'hC) begin
            errors++; $display("FAIL branch_not_taken: got %h want 0000000c", PC);
        end
    endtask

    task automatic test_jump_priority();
        set_pc(32'h1000_0000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'h0000010, 1'b0, 32'd0);
        checks++;
        if (PC !== 32'h1000_0040) begin
            errors++; $display("FAIL jump: got %h want 10000040", PC);
        end
        set_pc(32'h1000_0000);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 26'h0000010, 1'b1, 32'h20);
        checks++;
        if (PC !== 32'h20) begin
            errors++; $display("FAIL jr_priority: got %h want 00000020", PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            r[1:0] = 2'b00;
            cycle(($urandom_range(0, 7) != 0), 1'b0, 1'(($urandom_range(0, 2) == 0)), 1'($urandom),
                  16'($urandom), 1'(($urandom_range(0, 5) == 0)), 26'($urandom),
                  1'(($urandom_range(0, 7) == 0)), r);
            checks++;
            if (PC !== m_pc || PC_plus4 !== m_pc + 32'd4 || instr_count !== 32'(m_count) || valid !== 1'b1) begin
                errors++;
                $display("FAIL random%0d: PC=%h cnt=%0d valid=%b, want PC=%h cnt=%0d valid=1",
                         i, PC, instr_count, valid, m_pc, m_count);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] p, c;
        p = PC; c = instr_count;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 26'h3FF, 1'b0, 32'd0);
            checks++;
            if (PC !== p || instr_count !== c || valid !== 1'b1) begin
                errors++;
                $display("FAIL stall%0d: PC=%h cnt=%0d, want %h %0d", i, PC, instr_count, p, c);
            end
        end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        checks++;
        if (PC_plus4 !== 32'h0) begin
            errors++; $display("FAIL plus4_wrap: got %h want 00000000", PC_plus4);
        end
        seq(1'b1);
        checks++;
        if (PC !== 32'h0) begin
            errors++; $display("FAIL seq_wrap: got %h want 00000000", PC);
        end
        set_pc(32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 26'd0, 1'b0, 32'd0);
        checks++;
        if (PC !== 32'hC) begin
            errors++; $display("FAIL branch_wrap: got %h want 0000000c", PC);
        end
    endtask

    task automatic test_align();
        set_pc(32'h22);
        checks++;
        if (PC !== (ALIGN_CHK ? 32'h20 : 32'h22) || misalign !== ALIGN_CHK) begin
            errors++;
            $display("FAIL jr_align: PC=%h mis=%b, want %h %b", PC, misalign, ALIGN_CHK ? 32'h20 : 32'h22, ALIGN_CHK);
        end
        set_pc(32'h40);
        seq(1'b1);
        checks++;
        if (PC !== 32'h44 || misalign !== ALIGN_CHK) begin
            errors++; $display("FAIL misalign_sticky: PC=%h mis=%b, want 00000044 %b", PC, misalign, ALIGN_CHK);
        end
    endtask

    task automatic test_halt();
        logic [31:0] p, c;
        p = PC; c = instr_count;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        checks++;
        if (valid !== 1'b0 || PC !== p || instr_count !== c) begin
            errors++;
            $display("FAIL halt_edge: valid=%b PC=%h cnt=%0d, want 0 %h %0d", valid, PC, instr_count, p, c);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 26'h123, 1'b1, 32'h0000_0101);
            checks++;
            if (valid !== 1'b0 || PC !== p || instr_count !== c || misalign !== m_mis) begin
                errors++;
                $display("FAIL halted_frozen%0d: valid=%b PC=%h cnt=%0d mis=%b, want 0 %h %0d %b",
                         i, valid, PC, instr_count, misalign, p, c, m_mis);
            end
        end
    endtask

    task automatic test_async_reset();
        // from HALTED
        #2 reset = 1'b1;
        #1;
        checks++;
        if (PC !== 32'h0 || valid !== 1'b0 || instr_count !== 32'd0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_halted: PC=%h valid=%b cnt=%0d mis=%b, want 0", PC, valid, instr_count, misalign);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        seq(1'b1);
        for (int i = 0; i < 5; i++) seq(1'b1);
        checks++;
        if (PC !== 32'h14 || instr_count !== 32'd5 || valid !== 1'b1) begin
            errors++; $display("FAIL rerun: PC=%h cnt=%0d valid=%b, want 00000014 5 1", PC, instr_count, valid);
        end
        // mid-RUN, checked before the next rising edge
        #2 reset = 1'b1;
        #1;
        checks++;
        if (PC !== 32'h0 || instr_count !== 32'd0 || valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_run: PC=%h cnt=%0d valid=%b, want 0/0/0", PC, instr_count, valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_random();
        test_stall();
        test_wrap();
        test_align();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
